// File: rtl/mic_pkg.sv
// Shared constants and width helpers for the microphone decimator.
package mic_pkg;

    localparam int unsigned MIC_D_WIDTH = 8;

    // Accumulator width that holds the sum of 2^l samples of d bits.
    function automatic int unsigned acc_width(input int unsigned d, input int unsigned l);
        return d + l;
    endfunction

    // Largest unsigned sample value of width d (d below 32).
    function automatic int unsigned sample_max(input int unsigned d);
        return (32'd1 << d) - 32'd1;
    endfunction

    localparam int unsigned SAMPLE_MAX = sample_max(MIC_D_WIDTH);

endpackage

// File: rtl/mic_decimator_clip_detector.sv
// Flags full-scale samples and holds the flag for CLIP_HOLD cycles after the last one.
module clip_detector
    import mic_pkg::*;
#(
    parameter int unsigned D_WIDTH   = MIC_D_WIDTH,
    parameter int unsigned CLIP_HOLD = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               accept_i,
    input  logic [D_WIDTH-1:0] sample_i,
    output logic               clip_o
);

    localparam int unsigned HOLD_W = (CLIP_HOLD > 0) ? $clog2(CLIP_HOLD + 1) : 1;
    localparam logic [D_WIDTH-1:0] MAX_S = D_WIDTH'(sample_max(D_WIDTH));

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              clip_q, clip_d;
    logic              clipped_c;

    // Reload on a clipped sample, otherwise count the hold window down every cycle.
    always_comb begin
        hold_d    = hold_q;
        clip_d    = clip_q;
        clipped_c = accept_i && ((sample_i == '0) || (sample_i == MAX_S));
        if (clipped_c) begin
            hold_d = HOLD_W'(CLIP_HOLD);
            clip_d = (CLIP_HOLD != 0);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
            if (hold_q == HOLD_W'(1)) begin
                clip_d = 1'b0;
            end
        end
    end

    // Hold counter and clip flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            clip_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            clip_q <= clip_d;
        end
    end

    assign clip_o = clip_q;

endmodule

// File: rtl/mic_decimator.sv
// Averages each block of 2^LOG2_DEC accepted ADC samples into one output sample.
module mic_decimator
    import mic_pkg::*;
#(
    parameter int unsigned D_WIDTH   = MIC_D_WIDTH,
    parameter int unsigned LOG2_DEC  = 2,
    parameter int unsigned CLIP_HOLD = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               adc_valid,
    input  logic [D_WIDTH-1:0] adc_data,
    output logic [D_WIDTH-1:0] mic_signal,
    output logic               wr,
    output logic               clip
);

    localparam int unsigned ACC_W = acc_width(D_WIDTH, LOG2_DEC);
    localparam int unsigned CNT_W = (LOG2_DEC > 0) ? LOG2_DEC : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_DEC) - 1);

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [D_WIDTH-1:0] mic_q, mic_d;
    logic               wr_q, wr_d;
    logic [ACC_W-1:0]   sum_c;
    logic               accept_c;

    // Block fill / flush and floor-average on the final sample of each block.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mic_d    = mic_q;
        wr_d     = 1'b0;
        sum_c    = acc_q + ACC_W'(adc_data);
        accept_c = en && adc_valid;
        if (!en) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (adc_valid) begin
            if (cnt_q == CNT_LAST) begin
                mic_d = D_WIDTH'(sum_c >> LOG2_DEC);
                wr_d  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_c;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Accumulator, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            mic_q <= '0;
            wr_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            mic_q <= mic_d;
            wr_q  <= wr_d;
        end
    end

    clip_detector #(
        .D_WIDTH   (D_WIDTH),
        .CLIP_HOLD (CLIP_HOLD)
    ) u_clip (
        .clk      (clk),
        .rst      (rst),
        .accept_i (accept_c),
        .sample_i (adc_data),
        .clip_o   (clip)
    );

    assign mic_signal = mic_q;
    assign wr         = wr_q;

endmodule

// File: tb/tb_mic_decimator.sv
// Scoreboard bench for mic_decimator: directed test plan followed by random traffic.
module tb_mic_decimator;

    localparam int unsigned DW = 8;
    localparam int unsigned L2 = 2;
    localparam int unsigned CH = 8;
    localparam int          N  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic [DW-1:0] mic_signal;
    logic          wr;
    logic          clip;

    always #5 clk = ~clk;

    mic_decimator #(
        .D_WIDTH   (DW),
        .LOG2_DEC  (L2),
        .CLIP_HOLD (CH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .mic_signal (mic_signal),
        .wr         (wr),
        .clip       (clip)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: samples of the current block, expected averages,
    // last published average, and cycles since the most recent clipped sample.
    int blk[$];
    int exp_q[$];
    int cur_mic     = 0;
    bit has_clip    = 1'b0;
    int since_clip  = 0;
    bit started     = 1'b0;
    bit exp_wr;
    bit exp_clip;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs and advance the reference model over that edge.
    task automatic step(input bit r, input bit e, input bit v, input int d);
        int sum;
        rst       = r;
        en        = e;
        adc_valid = v;
        adc_data  = DW'(d);
        @(posedge clk);
        if (r) begin
            blk.delete();
            exp_q.delete();
            cur_mic  = 0;
            has_clip = 1'b0;
            started  = 1'b1;
        end else begin
            if (since_clip < 1000000) since_clip++;
            if (e && v) begin
                if (d == 0 || d == 255) begin
                    has_clip   = 1'b1;
                    since_clip = 0;
                end
                blk.push_back(d);
                if (blk.size() == N) begin
                    sum = 0;
                    foreach (blk[i]) sum += blk[i];
                    exp_q.push_back(sum / N);
                    blk.delete();
                end
            end
            if (!e) blk.delete();
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0);
    endtask

    // Feed a sequence with en high; negative entries are cycles without adc_valid.
    task automatic feed(input int vals[]);
        foreach (vals[i]) begin
            if (vals[i] < 0) step(1'b0, 1'b1, 1'b0, 0);
            else             step(1'b0, 1'b1, 1'b1, vals[i]);
        end
    endtask

    // Monitor: every cycle, compare the DUT outputs with the scoreboard.
    always @(posedge clk) begin
        #2;
        if (started) begin
            exp_wr = (exp_q.size() != 0);
            check("wr", 32'(wr), 32'(exp_wr));
            if (exp_wr) cur_mic = exp_q.pop_front();
            check("mic_signal", 32'(mic_signal), 32'(cur_mic));
            exp_clip = has_clip && (since_clip < int'(CH));
            check("clip", 32'(clip), 32'(exp_clip));
        end
    end

    initial begin
        int r;
        int d;
        // 1: reset, then idle with en high
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        idle(3);
        // 2: basic average
        feed('{10, 20, 30, 40});
        idle(3);
        // 3: floor rounding, full-scale block and clip window
        feed('{1, 2, 3, 3});
        feed('{255, 255, 255, 255});
        idle(12);
        // 4: gapped input
        feed('{50, -1, 50, -1, -1, 50, 50});
        idle(2);
        // 5: partial block flushed by en low
        feed('{7, 7, 7});
        step(1'b0, 1'b0, 1'b1, 7);
        feed('{100, 100, 100, 100});
        idle(2);
        // 6: reset mid-block
        feed('{200, 200});
        step(1'b1, 1'b1, 1'b1, 200);
        feed('{8, 8, 8, 8});
        idle(2);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      d = 0;
            else if (r == 1) d = 255;
            else             d = $urandom_range(0, 255);
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 14) != 0),
                 ($urandom_range(0, 9) < 7),
                 d);
        end
        idle(12);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
